// File: rtl/hpdcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_pkg
//  Purpose  : Shared types for the eviction controller: FSM state encoding,
//             eviction request record and writeback beat record, sized for
//             the default cache geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_WAYS       = 4;
  localparam int unsigned HPDCACHE_SETS       = 64;
  localparam int unsigned HPDCACHE_TAG_WIDTH  = 20;
  localparam int unsigned HPDCACHE_DATA_WIDTH = 64;
  localparam int unsigned HPDCACHE_BEATS      = 4;
  localparam int unsigned HPDCACHE_SET_W      = $clog2(HPDCACHE_SETS);
  localparam int unsigned HPDCACHE_BEAT_W     = $clog2(HPDCACHE_BEATS);
  localparam int unsigned HPDCACHE_OFF_W      = $clog2(HPDCACHE_BEATS * HPDCACHE_DATA_WIDTH / 8);
  localparam int unsigned HPDCACHE_ADDR_W     = HPDCACHE_TAG_WIDTH + HPDCACHE_SET_W + HPDCACHE_OFF_W;

  typedef enum logic [2:0] {
    HPDCACHE_EVICT_IDLE  = 3'd0,
    HPDCACHE_EVICT_READ  = 3'd1,
    HPDCACHE_EVICT_DRAIN = 3'd2,
    HPDCACHE_EVICT_SEND  = 3'd3,
    HPDCACHE_EVICT_INVAL = 3'd4
  } hpdcache_evict_fsm_e;

  typedef struct packed {
    logic [HPDCACHE_SET_W-1:0]     set;
    logic [HPDCACHE_WAYS-1:0]      way;
    logic [HPDCACHE_TAG_WIDTH-1:0] tag;
    logic                          valid;
    logic                          dirty;
  } hpdcache_evict_req_t;

  typedef struct packed {
    logic [HPDCACHE_ADDR_W-1:0]     addr;
    logic [HPDCACHE_DATA_WIDTH-1:0] data;
    logic [HPDCACHE_BEAT_W-1:0]     beat;
    logic                           last;
  } hpdcache_wb_beat_t;

endpackage
`default_nettype wire

// File: rtl/hpdcache_evict_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_evict_ctrl_if
//  Purpose  : Bundles the eviction request, data-array read, writeback and
//             directory-invalidate signals of the eviction controller.
//  Modports : master - controller view (drives *_o, samples *_i)
//             slave  - environment view (victim select, data array, memory,
//                      directory)
//  Revision : 1.0 - initial release
// ============================================================================
interface hpdcache_evict_ctrl_if #(
  parameter int unsigned Ways      = 4,
  parameter int unsigned Sets      = 64,
  parameter int unsigned TagWidth  = 20,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Beats     = 4
);
  localparam int unsigned SetW  = $clog2(Sets);
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(Beats * DataWidth / 8);
  localparam int unsigned AddrW = TagWidth + SetW + OffW;

  // eviction request
  logic                 evict_req_valid_i;
  logic                 evict_req_ready_o;
  logic [SetW-1:0]      evict_req_set_i;
  logic [Ways-1:0]      evict_req_way_i;
  logic [TagWidth-1:0]  evict_req_tag_i;
  logic                 evict_req_valid_line_i;
  logic                 evict_req_dirty_i;
  // data array read
  logic                 data_rd_o;
  logic [SetW-1:0]      data_rd_set_o;
  logic [Ways-1:0]      data_rd_way_o;
  logic [BeatW-1:0]     data_rd_beat_o;
  logic                 data_rd_gnt_i;
  logic [DataWidth-1:0] data_rd_data_i;
  // memory writeback
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [AddrW-1:0]     wb_addr_o;
  logic [DataWidth-1:0] wb_data_o;
  logic [BeatW-1:0]     wb_beat_o;
  logic                 wb_last_o;
  // directory invalidate
  logic                 dir_inval_o;
  logic [SetW-1:0]      dir_inval_set_o;
  logic [Ways-1:0]      dir_inval_way_o;
  logic                 busy_o;

  modport master (
    input  evict_req_valid_i, evict_req_set_i, evict_req_way_i, evict_req_tag_i,
           evict_req_valid_line_i, evict_req_dirty_i,
           data_rd_gnt_i, data_rd_data_i, wb_ready_i,
    output evict_req_ready_o, data_rd_o, data_rd_set_o, data_rd_way_o, data_rd_beat_o,
           wb_valid_o, wb_addr_o, wb_data_o, wb_beat_o, wb_last_o,
           dir_inval_o, dir_inval_set_o, dir_inval_way_o, busy_o
  );

  modport slave (
    output evict_req_valid_i, evict_req_set_i, evict_req_way_i, evict_req_tag_i,
           evict_req_valid_line_i, evict_req_dirty_i,
           data_rd_gnt_i, data_rd_data_i, wb_ready_i,
    input  evict_req_ready_o, data_rd_o, data_rd_set_o, data_rd_way_o, data_rd_beat_o,
           wb_valid_o, wb_addr_o, wb_data_o, wb_beat_o, wb_last_o,
           dir_inval_o, dir_inval_set_o, dir_inval_way_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/hpdcache_evict_linebuf.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_evict_linebuf
//  Purpose  : Holds one cache line (Beats x DataWidth) between the data-array
//             read and the memory writeback. Contents are never reset.
//  Ports    : clk_i     - clock
//             wen_i     - write enable
//             windex_i  - beat index to write
//             wdata_i   - beat data to write
//             rindex_i  - beat index to read (combinational)
//             rdata_o   - beat data read
//  Revision : 1.0 - initial release
// ============================================================================
module hpdcache_evict_linebuf #(
  parameter int unsigned Beats     = 4,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned BeatW    = $clog2(Beats)
) (
  input  logic                 clk_i,
  input  logic                 wen_i,
  input  logic [BeatW-1:0]     windex_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeatW-1:0]     rindex_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] buf_q [Beats];

  for (genvar i = 0; i < Beats; i++) begin : g_entry
    logic [DataWidth-1:0] entry_d;

    always_comb begin
      entry_d = buf_q[i];
      if (wen_i && (windex_i == BeatW'(i))) begin
        entry_d = wdata_i;
      end
    end

    always_ff @(posedge clk_i) begin
      buf_q[i] <= entry_d;
    end
  end

  assign rdata_o = buf_q[rindex_i];

endmodule
`default_nettype wire

// File: rtl/hpdcache_evict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_evict_ctrl
//  Purpose  : Eviction controller behind victim selection. Dirty valid lines
//             are read beat by beat into a local line buffer, written back to
//             memory, then invalidated; clean valid lines are only
//             invalidated; invalid lines are consumed with no side effect.
//  Ports    : clk_i  - clock
//             rst_i  - asynchronous active-high reset
//             bus    - request / data-read / writeback / invalidate bundle
//                      (hpdcache_evict_ctrl_if.master)
//  Revision : 1.0 - initial release
// ============================================================================
module hpdcache_evict_ctrl
  import hpdcache_pkg::*;
#(
  parameter int unsigned Ways      = 4,
  parameter int unsigned Sets      = 64,
  parameter int unsigned TagWidth  = 20,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Beats     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  hpdcache_evict_ctrl_if.master  bus
);

  localparam int unsigned SetW  = $clog2(Sets);
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(Beats * DataWidth / 8);

  localparam logic [2:0] ST_IDLE  = HPDCACHE_EVICT_IDLE;
  localparam logic [2:0] ST_READ  = HPDCACHE_EVICT_READ;
  localparam logic [2:0] ST_DRAIN = HPDCACHE_EVICT_DRAIN;
  localparam logic [2:0] ST_SEND  = HPDCACHE_EVICT_SEND;
  localparam logic [2:0] ST_INVAL = HPDCACHE_EVICT_INVAL;

  localparam logic [BeatW-1:0] LAST_BEAT = BeatW'(Beats - 1);

  logic [2:0]          state_q, state_d;
  logic [BeatW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [BeatW-1:0]    wb_cnt_q, wb_cnt_d;
  logic [SetW-1:0]     set_q, set_d;
  logic [Ways-1:0]     way_q, way_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  // A granted read returns data on the following cycle; remember which beat.
  logic                rd_pend_q, rd_pend_d;
  logic [BeatW-1:0]    rd_pend_beat_q, rd_pend_beat_d;

  logic                 accept;
  logic                 rd_fire;
  logic                 wb_fire;
  logic [DataWidth-1:0] buf_rdata;

  assign accept  = bus.evict_req_valid_i && (state_q == ST_IDLE);
  assign rd_fire = (state_q == ST_READ) && bus.data_rd_gnt_i;
  assign wb_fire = (state_q == ST_SEND) && bus.wb_ready_i;

  always_comb begin
    state_d        = state_q;
    rd_cnt_d       = rd_cnt_q;
    wb_cnt_d       = wb_cnt_q;
    set_d          = set_q;
    way_d          = way_q;
    tag_d          = tag_q;
    rd_pend_d      = rd_fire;
    rd_pend_beat_d = rd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          set_d = bus.evict_req_set_i;
          way_d = bus.evict_req_way_i;
          tag_d = bus.evict_req_tag_i;
          // The dirty flag only matters for a valid line.
          if (bus.evict_req_valid_line_i && bus.evict_req_dirty_i) begin
            state_d  = ST_READ;
            rd_cnt_d = '0;
          end else if (bus.evict_req_valid_line_i) begin
            state_d = ST_INVAL;
          end
        end
      end
      ST_READ: begin
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + BeatW'(1);
          if (rd_cnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Last read beat lands in the buffer during this cycle.
        state_d  = ST_SEND;
        wb_cnt_d = '0;
      end
      ST_SEND: begin
        if (wb_fire) begin
          wb_cnt_d = wb_cnt_q + BeatW'(1);
          if (wb_cnt_q == LAST_BEAT) begin
            state_d = ST_INVAL;
          end
        end
      end
      ST_INVAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      rd_cnt_q       <= '0;
      wb_cnt_q       <= '0;
      set_q          <= '0;
      way_q          <= '0;
      tag_q          <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_beat_q <= '0;
    end else begin
      state_q        <= state_d;
      rd_cnt_q       <= rd_cnt_d;
      wb_cnt_q       <= wb_cnt_d;
      set_q          <= set_d;
      way_q          <= way_d;
      tag_q          <= tag_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_beat_q <= rd_pend_beat_d;
    end
  end

  hpdcache_evict_linebuf #(
    .Beats     (Beats),
    .DataWidth (DataWidth)
  ) u_linebuf (
    .clk_i    (clk_i),
    .wen_i    (rd_pend_q),
    .windex_i (rd_pend_beat_q),
    .wdata_i  (bus.data_rd_data_i),
    .rindex_i (wb_cnt_q),
    .rdata_o  (buf_rdata)
  );

  // Address/data fields are forced to zero outside their owning state so the
  // bus is quiet whenever the corresponding valid is low.
  assign bus.evict_req_ready_o = (state_q == ST_IDLE);
  assign bus.busy_o            = (state_q != ST_IDLE);

  assign bus.data_rd_o      = (state_q == ST_READ);
  assign bus.data_rd_set_o  = (state_q == ST_READ) ? set_q    : '0;
  assign bus.data_rd_way_o  = (state_q == ST_READ) ? way_q    : '0;
  assign bus.data_rd_beat_o = (state_q == ST_READ) ? rd_cnt_q : '0;

  assign bus.wb_valid_o = (state_q == ST_SEND);
  assign bus.wb_addr_o  = (state_q == ST_SEND) ? {tag_q, set_q, {OffW{1'b0}}} : '0;
  assign bus.wb_data_o  = (state_q == ST_SEND) ? buf_rdata : '0;
  assign bus.wb_beat_o  = (state_q == ST_SEND) ? wb_cnt_q  : '0;
  assign bus.wb_last_o  = (state_q == ST_SEND) && (wb_cnt_q == LAST_BEAT);

  assign bus.dir_inval_o     = (state_q == ST_INVAL);
  assign bus.dir_inval_set_o = (state_q == ST_INVAL) ? set_q : '0;
  assign bus.dir_inval_way_o = (state_q == ST_INVAL) ? way_q : '0;

`ifndef HPDCACHE_ASSERT_OFF
  a_way_onehot : assert property (
    @(posedge clk_i) disable iff (rst_i)
      accept |-> $onehot(bus.evict_req_way_i)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_evict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpdcache_evict_ctrl
//  Purpose  : Self-checking bench for hpdcache_evict_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hpdcache_evict_ctrl;

  localparam int unsigned Ways      = 4;
  localparam int unsigned Sets      = 64;
  localparam int unsigned TagWidth  = 20;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned Beats     = 4;
  localparam int unsigned AddrW     = 31;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  hpdcache_evict_ctrl_if #(
    .Ways(Ways), .Sets(Sets), .TagWidth(TagWidth), .DataWidth(DataWidth), .Beats(Beats)
  ) bus ();

  hpdcache_evict_ctrl #(
    .Ways(Ways), .Sets(Sets), .TagWidth(TagWidth), .DataWidth(DataWidth), .Beats(Beats)
  ) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  set;
    logic [3:0]  way;
    logic [19:0] tag;
    logic        vl;
    logic        dirty;
    logic [63:0] base;     // beat b of the line holds base + b
    int          gmode;    // 0: grant always, 1: grant after 2 wait cycles
    int          rmode;    // 0: wb_ready always, 1: toggling
    int          n_rd;
    int          n_wb;
    int          n_inv;
    int          inv_cyc;  // -1: not checked
    int          rdy_cyc;  // -1: not checked
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.evict_req_ready_o, 1);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_valids"}, {bus.data_rd_o, bus.wb_valid_o, bus.wb_last_o, bus.dir_inval_o}, 0);
    chk({tag, "_rd_fields"}, {bus.data_rd_set_o, bus.data_rd_way_o, bus.data_rd_beat_o}, 0);
    chk({tag, "_wb_addr_beat"}, {bus.wb_addr_o, bus.wb_beat_o}, 0);
    chk({tag, "_wb_data"}, bus.wb_data_o, 0);
    chk({tag, "_inv_fields"}, {bus.dir_inval_set_o, bus.dir_inval_way_o}, 0);
  endtask

  // One eviction: accept in cycle 0, then model data array / memory and
  // check every visible beat against the bench's own expectations.
  task automatic run(input string nm, input vec_t v, input int abort_beat, output bit aborted);
    int n_rd, n_wb, n_inv, inv_c, rdy_c, rbeat, wbeat, wait_cnt;
    bit pend;
    logic [1:0] pend_beat;
    logic [AddrW-1:0] exp_addr;
    exp_addr = {v.tag, v.set, 5'b0};
    aborted = 0;
    n_rd = 0; n_wb = 0; n_inv = 0; inv_c = -1; rdy_c = -1;
    rbeat = 0; wbeat = 0; wait_cnt = 0; pend = 0; pend_beat = 0;

    @(negedge clk_i);
    chk({nm, "_accept_ready"}, bus.evict_req_ready_o, 1);
    bus.evict_req_valid_i      = 1'b1;
    bus.evict_req_set_i        = v.set;
    bus.evict_req_way_i        = v.way;
    bus.evict_req_tag_i        = v.tag;
    bus.evict_req_valid_line_i = v.vl;
    bus.evict_req_dirty_i      = v.dirty;
    bus.data_rd_gnt_i          = 1'b0;
    bus.wb_ready_i             = 1'b0;

    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk_i);
      bus.evict_req_valid_i = 1'b0;
      // data for a read granted last cycle
      bus.data_rd_data_i = pend ? v.base + 64'(pend_beat) : (64'hBAD0_0000_0000_0000 | 64'(cyc));
      pend = 0;

      if (bus.data_rd_o) begin
        chk({nm, "_rd_beat"}, bus.data_rd_beat_o, 64'(rbeat));
        chk({nm, "_rd_setway"}, {bus.data_rd_set_o, bus.data_rd_way_o}, {v.set, v.way});
        if (v.gmode == 0 || wait_cnt == 2) begin
          bus.data_rd_gnt_i = 1'b1;
          wait_cnt = 0;
          pend = 1;
          pend_beat = 2'(rbeat);
          rbeat++;
          n_rd++;
        end else begin
          bus.data_rd_gnt_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.data_rd_gnt_i = 1'b0;
      end

      if (bus.wb_valid_o) begin
        chk({nm, "_wb_beat"}, bus.wb_beat_o, 64'(wbeat));
        chk({nm, "_wb_data"}, bus.wb_data_o, v.base + 64'(wbeat));
        chk({nm, "_wb_last"}, bus.wb_last_o, (wbeat == Beats - 1) ? 1 : 0);
        chk({nm, "_wb_addr"}, bus.wb_addr_o, exp_addr);
        if (abort_beat >= 0 && wbeat == abort_beat) begin
          bus.wb_ready_i = 1'b0;
          aborted = 1;
          return;
        end
        bus.wb_ready_i = (v.rmode == 0) ? 1'b1 : ((cyc % 2) == 1);
        if (bus.wb_ready_i) begin
          wbeat++;
          n_wb++;
        end
      end else begin
        bus.wb_ready_i = (v.rmode == 0) ? 1'b1 : 1'b0;
        if (bus.wb_last_o) chk({nm, "_wb_last_idle"}, bus.wb_last_o, 0);
      end

      if (bus.dir_inval_o) begin
        chk({nm, "_inv_setway"}, {bus.dir_inval_set_o, bus.dir_inval_way_o}, {v.set, v.way});
        n_inv++;
        inv_c = cyc;
      end

      if (bus.evict_req_ready_o) begin
        chk({nm, "_busy_idle"}, bus.busy_o, 0);
        rdy_c = cyc;
        break;
      end
    end

    if (rdy_c < 0) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_n_rd"}, 64'(n_rd), 64'(v.n_rd));
    chk({nm, "_n_wb"}, 64'(n_wb), 64'(v.n_wb));
    chk({nm, "_n_inv"}, 64'(n_inv), 64'(v.n_inv));
    if (v.inv_cyc >= 0) chk({nm, "_inv_cyc"}, 64'(inv_c), 64'(v.inv_cyc));
    if (v.rdy_cyc >= 0) chk({nm, "_rdy_cyc"}, 64'(rdy_c), 64'(v.rdy_cyc));
  endtask

  initial begin
    bit ab;
    bit act;
    //            set    way      tag        vl dirty base                      g  r  rd wb inv invc rdyc
    vecs[0] = '{6'd5,  4'b0100, 20'h12345, 1, 1, 64'h00A0,                 0, 0, 4, 4, 1, 10, 11};
    vecs[1] = '{6'd63, 4'b0001, 20'h00001, 1, 0, 64'h0,                    0, 0, 0, 0, 1,  1,  2};
    vecs[2] = '{6'd10, 4'b1000, 20'h0ABCD, 0, 1, 64'h0,                    0, 0, 0, 0, 0, -1,  1};
    vecs[3] = '{6'd33, 4'b0010, 20'hFEDCB, 1, 1, 64'h5500,                 1, 1, 4, 4, 1, -1, -1};
    vecs[4] = '{6'd0,  4'b1000, 20'hFFFFF, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC,  0, 0, 4, 4, 1, 10, 11};
    vecs[5] = '{6'd0,  4'b1000, 20'h00000, 1, 0, 64'h0,                    0, 0, 0, 0, 1,  1,  2};

    rst_i = 1'b1;
    bus.evict_req_valid_i      = 1'b0;
    bus.evict_req_set_i        = '0;
    bus.evict_req_way_i        = 4'b0001;
    bus.evict_req_tag_i        = '0;
    bus.evict_req_valid_line_i = 1'b0;
    bus.evict_req_dirty_i      = 1'b0;
    bus.data_rd_gnt_i          = 1'b0;
    bus.data_rd_data_i         = '0;
    bus.wb_ready_i             = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_vals("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run($sformatf("vec%0d", i), vecs[i], -1, ab);
    end

    // Three back-to-back invalid lines (dirty set) accepted on consecutive cycles.
    act = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("b2b_ready%0d", i), bus.evict_req_ready_o, 1);
      act |= bus.data_rd_o | bus.wb_valid_o | bus.dir_inval_o;
      bus.evict_req_valid_i      = 1'b1;
      bus.evict_req_set_i        = 6'(i + 1);
      bus.evict_req_way_i        = 4'(1 << i);
      bus.evict_req_valid_line_i = 1'b0;
      bus.evict_req_dirty_i      = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      bus.evict_req_valid_i = 1'b0;
      act |= bus.data_rd_o | bus.wb_valid_o | bus.dir_inval_o | bus.busy_o;
      if (i == 0) chk("b2b_ready_after", bus.evict_req_ready_o, 1);
    end
    chk("b2b_no_activity", act, 0);

    // Reset while beat 2 of a writeback is presented.
    run("rst_mid", vecs[0], 2, ab);
    chk("rst_mid_reached_beat2", ab, 1);
    rst_i = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk_i);
    check_reset_vals("rst_mid_hold");
    rst_i = 1'b0;
    vecs[0].base = 64'h00B0;
    run("after_rst", vecs[0], -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
